// File: rtl/multdiv_wb_ctrl.sv
// multdiv_wb_ctrl: tracks a single in-flight mult/div launched from DX,
// stalls DX on hazards against the pending result, and writes the result
// into the regfile in a cycle where the MW stage leaves the write port free.
//
// state | meaning
// IDLE  | nothing in flight, DX mult/div may launch
// BUSY  | op launched, waiting for the multdiv result
// HOLD  | result captured, waiting for a free regfile write port
module multdiv_wb_ctrl #(
  parameter logic [4:0]  OP_ALU     = 5'b00000,
  parameter logic [4:0]  ALUOP_MULT = 5'b00110,
  parameter logic [4:0]  ALUOP_DIV  = 5'b00111,
  parameter logic [4:0]  RSTATUS    = 5'd30,
  parameter logic [31:0] EXC_MULT   = 32'd4,
  parameter logic [31:0] EXC_DIV    = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_instruction,
  input  logic [31:0] dx_operandA,
  input  logic [31:0] dx_operandB,
  input  logic        pipe_stall,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        mw_writeReg,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_dataA,
  output logic [31:0] md_dataB,
  output logic        md_stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  // Opcodes of the other instructions that write their rd field.
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        ctrl_mult_q;
  logic        ctrl_div_q;
  logic [31:0] data_a_q;
  logic [31:0] data_b_q;

  logic [4:0] dx_opcode;
  logic [4:0] dx_aluop;
  logic [4:0] dx_rd;
  logic [4:0] dx_rs;
  logic [4:0] dx_rt;
  logic       dx_is_md;
  logic       dx_is_div;
  logic       dx_writes_rd;
  logic       haz_raw;
  logic       haz_waw;
  logic       haz_rstatus;
  logic       in_hold;
  logic       hold_no_write;
  logic       launch_pulse;
  logic       unused_bits;

  assign dx_opcode = dx_instruction[31:27];
  assign dx_rd     = dx_instruction[26:22];
  assign dx_rs     = dx_instruction[21:17];
  assign dx_rt     = dx_instruction[16:12];
  assign dx_aluop  = dx_instruction[6:2];

  // shamt and the low two bits carry nothing this block needs.
  assign unused_bits = ^{dx_instruction[11:7], dx_instruction[1:0]};

  assign dx_is_md  = (dx_opcode == OP_ALU) &&
                     ((dx_aluop == ALUOP_MULT) || (dx_aluop == ALUOP_DIV));
  assign dx_is_div = (dx_aluop == ALUOP_DIV);

  assign dx_writes_rd = (dx_opcode == OP_ALU) || (dx_opcode == OP_ADDI) ||
                        (dx_opcode == OP_LW);

  assign haz_raw = ((dx_rs != 5'd0) && (dx_rs == rd_q)) ||
                   ((dx_rt != 5'd0) && (dx_rt == rd_q));

  // A pending write to r0 never lands, so it cannot order against DX.
  assign haz_waw = dx_writes_rd && (rd_q != 5'd0) && (dx_rd == rd_q);

  // Both mult and div can overflow into rstatus.
  assign haz_rstatus = (dx_rs == RSTATUS) || (dx_rt == RSTATUS);

  // Hold DX whenever it conflicts with the op in flight.
  always_comb begin
    md_stall = 1'b0;
    if (state_q != S_IDLE) begin
      md_stall = dx_is_md || haz_raw || haz_waw || haz_rstatus;
    end
  end

  assign in_hold       = (state_q == S_HOLD);
  assign hold_no_write = (rd_q == 5'd0) && !exc_q;
  assign launch_pulse  = ctrl_mult_q || ctrl_div_q;

  // Regfile write port: MW always wins, the result waits in HOLD.
  always_comb begin
    wb_en   = 1'b0;
    wb_rd   = 5'd0;
    wb_data = 32'd0;
    if (in_hold) begin
      wb_en = !mw_writeReg && !hold_no_write;
      if (exc_q) begin
        wb_rd   = RSTATUS;
        wb_data = is_div_q ? EXC_DIV : EXC_MULT;
      end else begin
        wb_rd   = rd_q;
        wb_data = result_q;
      end
    end
  end

  assign md_ctrl_mult = ctrl_mult_q;
  assign md_ctrl_div  = ctrl_div_q;
  assign md_dataA     = data_a_q;
  assign md_dataB     = data_b_q;

  // Launch / wait / writeback sequencing with registered start pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_q        <= 5'd0;
      is_div_q    <= 1'b0;
      result_q    <= 32'd0;
      exc_q       <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      data_a_q    <= 32'd0;
      data_b_q    <= 32'd0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dx_is_md && !pipe_stall) begin
            state_q     <= S_BUSY;
            rd_q        <= dx_rd;
            is_div_q    <= dx_is_div;
            result_q    <= 32'd0;
            exc_q       <= 1'b0;
            ctrl_mult_q <= !dx_is_div;
            ctrl_div_q  <= dx_is_div;
            data_a_q    <= dx_operandA;
            data_b_q    <= dx_operandB;
          end
        end
        S_BUSY: begin
          // A ready seen alongside our own start pulse belongs to an older op.
          if (md_ready && !launch_pulse) begin
            state_q  <= S_HOLD;
            result_q <= md_result;
            exc_q    <= md_exception;
          end
        end
        S_HOLD: begin
          if (!mw_writeReg || hold_no_write) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_wb_ctrl.sv
// Bench for multdiv_wb_ctrl: directed scenarios, an abstract reference
// model compared every cycle, and literal expectations at key cycles.
module tb_multdiv_wb_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dx_instruction = 32'd0;
  logic [31:0] dx_operandA = 32'd0;
  logic [31:0] dx_operandB = 32'd0;
  logic        pipe_stall = 1'b0;
  logic        md_ready = 1'b0;
  logic [31:0] md_result = 32'd0;
  logic        md_exception = 1'b0;
  logic        mw_writeReg = 1'b0;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_dataA;
  logic [31:0] md_dataB;
  logic        md_stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;
  int n_mult = 0;
  int n_div  = 0;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;
  localparam logic [31:0] NOP = 32'd0;

  multdiv_wb_ctrl dut (
    .clock(clock), .reset(reset),
    .dx_instruction(dx_instruction), .dx_operandA(dx_operandA), .dx_operandB(dx_operandB),
    .pipe_stall(pipe_stall), .md_ready(md_ready), .md_result(md_result),
    .md_exception(md_exception), .mw_writeReg(mw_writeReg),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_dataA(md_dataA), .md_dataB(md_dataB), .md_stall(md_stall),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] aluop, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {5'd0, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One pending operation: launched, optionally finished, then retired on write.
  logic        m_pending = 0;
  logic        m_finished = 0;
  int          m_age = 0;
  logic [4:0]  m_rd = 0;
  logic        m_div = 0;
  logic [31:0] m_res = 0;
  logic        m_exc = 0;
  logic [31:0] m_a = 0;
  logic [31:0] m_b = 0;
  logic        m_pm = 0;
  logic        m_pd = 0;

  function automatic logic is_md(input logic [31:0] ins);
    return ins[31:27] == 5'd0 && (ins[6:2] == ALU_MUL || ins[6:2] == ALU_DIV);
  endfunction

  function automatic logic hazard(input logic [31:0] ins, input logic [4:0] prd);
    logic [4:0] op, rd, rs, rt;
    logic writes;
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    writes = (op == 5'd0) || (op == 5'b00101) || (op == 5'b01000);
    if (is_md(ins)) return 1'b1;
    if (rs != 0 && rs == prd) return 1'b1;
    if (rt != 0 && rt == prd) return 1'b1;
    if (writes && prd != 0 && rd == prd) return 1'b1;
    if (rs == 5'd30 || rt == 5'd30) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_pending <= 0; m_finished <= 0; m_age <= 0; m_rd <= 0; m_div <= 0;
      m_res <= 0; m_exc <= 0; m_a <= 0; m_b <= 0; m_pm <= 0; m_pd <= 0;
    end else begin
      m_pm <= 0;
      m_pd <= 0;
      if (!m_pending) begin
        if (is_md(dx_instruction) && !pipe_stall) begin
          m_pending  <= 1;
          m_finished <= 0;
          m_age      <= 0;
          m_rd       <= dx_instruction[26:22];
          m_div      <= dx_instruction[6:2] == ALU_DIV;
          m_pm       <= dx_instruction[6:2] == ALU_MUL;
          m_pd       <= dx_instruction[6:2] == ALU_DIV;
          m_a        <= dx_operandA;
          m_b        <= dx_operandB;
          m_res      <= 0;
          m_exc      <= 0;
        end
      end else if (!m_finished) begin
        if (md_ready && m_age > 0) begin
          m_finished <= 1;
          m_res      <= md_result;
          m_exc      <= md_exception;
        end
        m_age <= m_age + 1;
      end else if (!mw_writeReg || (m_rd == 0 && !m_exc)) begin
        m_pending  <= 0;
        m_finished <= 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    logic        e_hold, e_en, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    e_hold  = m_pending && m_finished;
    e_stall = m_pending && hazard(dx_instruction, m_rd);
    e_en    = e_hold && !mw_writeReg && !(m_rd == 0 && !m_exc);
    e_rd    = e_hold ? (m_exc ? 5'd30 : m_rd) : 5'd0;
    e_data  = e_hold ? (m_exc ? (m_div ? 32'd5 : 32'd4) : m_res) : 32'd0;
    if (!reset) begin
      e_stall = 0; e_en = 0; e_rd = 0; e_data = 0;
    end
    chk("model md_ctrl_mult", {31'd0, md_ctrl_mult}, {31'd0, reset ? m_pm : 1'b0});
    chk("model md_ctrl_div", {31'd0, md_ctrl_div}, {31'd0, reset ? m_pd : 1'b0});
    chk("model md_dataA", md_dataA, reset ? m_a : 32'd0);
    chk("model md_dataB", md_dataB, reset ? m_b : 32'd0);
    chk("model md_stall", {31'd0, md_stall}, {31'd0, e_stall});
    chk("model wb_en", {31'd0, wb_en}, {31'd0, e_en});
    chk("model wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
    chk("model wb_data", wb_data, e_data);
  end

  always @(negedge clock) begin
    if (md_ctrl_mult) n_mult++;
    if (md_ctrl_div) n_div++;
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    dx_instruction = ins; dx_operandA = a; dx_operandB = b;
    next();
    dx_instruction = NOP; dx_operandA = 0; dx_operandB = 0;
  endtask

  task automatic finish_op(input int lat, input logic [31:0] res, input logic exc);
    repeat (lat) next();
    md_ready = 1; md_result = res; md_exception = exc;
    next();
    md_ready = 0; md_result = 0; md_exception = 0;
  endtask

  initial begin
    int base;
    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset md_stall", {31'd0, md_stall}, 32'd0);
    chk("reset wb_en", {31'd0, wb_en}, 32'd0);
    chk("reset md_dataA", md_dataA, 32'd0);
    @(posedge clock); #1;
    reset = 1;
    next();

    // 1: mul r3 = 6*7, ready 17 cycles after DX
    launch(rtype(ALU_MUL, 3, 1, 2), 6, 7);
    @(negedge clock);
    chk("t1 mult pulse", {31'd0, md_ctrl_mult}, 32'd1);
    chk("t1 div pulse", {31'd0, md_ctrl_div}, 32'd0);
    chk("t1 dataA", md_dataA, 32'd6);
    chk("t1 dataB", md_dataB, 32'd7);
    finish_op(16, 32'd42, 0);
    @(negedge clock);
    chk("t1 wb_en", {31'd0, wb_en}, 32'd1);
    chk("t1 wb_rd", {27'd0, wb_rd}, 32'd3);
    chk("t1 wb_data", wb_data, 32'd42);
    next();
    @(negedge clock);
    chk("t1 idle wb_en", {31'd0, wb_en}, 32'd0);
    chk("t1 dataA stable", md_dataA, 32'd6);
    next();

    // 2: div r4 with exception, MW busy for 3 cycles
    launch(rtype(ALU_DIV, 4, 1, 2), 9, 0);
    @(negedge clock);
    chk("t2 div pulse", {31'd0, md_ctrl_div}, 32'd1);
    chk("t2 mult pulse", {31'd0, md_ctrl_mult}, 32'd0);
    finish_op(3, 32'd0, 1);
    mw_writeReg = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t2 wb_en blocked", {31'd0, wb_en}, 32'd0);
      next();
    end
    mw_writeReg = 0;
    @(negedge clock);
    chk("t2 wb_en", {31'd0, wb_en}, 32'd1);
    chk("t2 wb_rd", {27'd0, wb_rd}, 32'd30);
    chk("t2 wb_data", wb_data, 32'd5);
    next();
    @(negedge clock);
    chk("t2 idle wb_en", {31'd0, wb_en}, 32'd0);
    next();

    // 3: RAW / independent / WAW / rstatus read
    launch(rtype(ALU_MUL, 5, 1, 2), 3, 4);
    dx_instruction = rtype(ALU_ADD, 6, 5, 1);
    @(negedge clock);
    chk("t3 raw stall", {31'd0, md_stall}, 32'd1);
    finish_op(4, 32'd12, 0);
    @(negedge clock);
    chk("t3 wb_en", {31'd0, wb_en}, 32'd1);
    chk("t3 wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("t3 wb_data", wb_data, 32'd12);
    chk("t3 stall in hold", {31'd0, md_stall}, 32'd1);
    next();
    @(negedge clock);
    chk("t3 stall released", {31'd0, md_stall}, 32'd0);
    next();
    launch(rtype(ALU_MUL, 5, 1, 2), 3, 4);
    dx_instruction = rtype(ALU_ADD, 6, 7, 1);
    @(negedge clock);
    chk("t3 independent", {31'd0, md_stall}, 32'd0);
    next();
    dx_instruction = rtype(ALU_ADD, 5, 7, 1);
    @(negedge clock);
    chk("t3 waw stall", {31'd0, md_stall}, 32'd1);
    next();
    dx_instruction = rtype(ALU_ADD, 6, 30, 2);
    @(negedge clock);
    chk("t3 rstatus stall", {31'd0, md_stall}, 32'd1);
    next();
    dx_instruction = NOP;
    finish_op(2, 32'd12, 0);
    next();

    // 4: back-to-back mul then div
    base = n_div;
    launch(rtype(ALU_MUL, 8, 1, 2), 2, 5);
    dx_instruction = rtype(ALU_DIV, 9, 1, 2); dx_operandA = 100; dx_operandB = 7;
    @(negedge clock);
    chk("t4 structural stall", {31'd0, md_stall}, 32'd1);
    finish_op(3, 32'd10, 0);
    @(negedge clock);
    chk("t4 wb_rd", {27'd0, wb_rd}, 32'd8);
    chk("t4 wb_data", wb_data, 32'd10);
    chk("t4 no early div", n_div - base, 0);
    next();
    @(negedge clock);
    chk("t4 idle stall", {31'd0, md_stall}, 32'd0);
    next();
    dx_instruction = NOP; dx_operandA = 0; dx_operandB = 0;
    @(negedge clock);
    chk("t4 div pulse", {31'd0, md_ctrl_div}, 32'd1);
    chk("t4 dataA", md_dataA, 32'd100);
    chk("t4 dataB", md_dataB, 32'd7);
    repeat (3) next();
    chk("t4 div pulse count", n_div - base, 1);
    finish_op(1, 32'd14, 0);
    @(negedge clock);
    chk("t4 div wb_rd", {27'd0, wb_rd}, 32'd9);
    chk("t4 div wb_data", wb_data, 32'd14);
    next();

    // 5: mul held by pipe_stall for 2 cycles
    base = n_mult;
    dx_instruction = rtype(ALU_MUL, 10, 1, 2); dx_operandA = 11; dx_operandB = 7;
    pipe_stall = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("t5 no launch", {31'd0, md_ctrl_mult}, 32'd0);
      next();
    end
    pipe_stall = 0;
    @(negedge clock);
    chk("t5 still idle", {31'd0, md_ctrl_mult}, 32'd0);
    next();
    dx_instruction = NOP; dx_operandA = 0; dx_operandB = 0;
    @(negedge clock);
    chk("t5 mult pulse", {31'd0, md_ctrl_mult}, 32'd1);
    chk("t5 dataA", md_dataA, 32'd11);
    repeat (3) next();
    chk("t5 pulse count", n_mult - base, 1);
    finish_op(1, 32'd77, 0);
    @(negedge clock);
    chk("t5 wb_rd", {27'd0, wb_rd}, 32'd10);
    chk("t5 wb_data", wb_data, 32'd77);
    next();

    // 6: reset while BUSY, then stray md_ready
    launch(rtype(ALU_MUL, 11, 1, 2), 5, 5);
    repeat (2) next();
    reset = 0;
    @(negedge clock);
    chk("t6 reset stall", {31'd0, md_stall}, 32'd0);
    chk("t6 reset dataA", md_dataA, 32'd0);
    chk("t6 reset wb_en", {31'd0, wb_en}, 32'd0);
    next();
    reset = 1;
    md_ready = 1; md_result = 25;
    next();
    md_ready = 0; md_result = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t6 no wb", {31'd0, wb_en}, 32'd0);
      next();
    end

    // mul r0: no write, readers of r0 not stalled
    launch(rtype(ALU_MUL, 0, 1, 2), 1, 2);
    dx_instruction = rtype(ALU_ADD, 6, 0, 0);
    @(negedge clock);
    chk("t6 r0 reader", {31'd0, md_stall}, 32'd0);
    finish_op(2, 32'd99, 0);
    @(negedge clock);
    chk("t6 r0 no wb", {31'd0, wb_en}, 32'd0);
    next();
    @(negedge clock);
    chk("t6 r0 idle stall", {31'd0, md_stall}, 32'd0);
    dx_instruction = NOP;
    repeat (2) next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
